computedram_sequencer: RTL and testbench

- Timing-violating DRAM row-operation sequencer inside the DRAM core, ComputeDRAM style (row copy / charge-sharing operations).
- On request it takes the DRAM command bus from the normal controller and issues PRE_ALL, ACT R1, PRE, ACT R2, PRE_ALL.
- The gaps between these commands are user-programmed NOP counts T1/T2. After the sequence it returns the bus to the controller.

---
 rtl/computedram_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_computedram_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/computedram_sequencer.sv
// Timing-violating DRAM row-operation sequencer (PRE_ALL, ACT R1, PRE, ACT R2, PRE_ALL).
// Optional status outputs (done pulse, op counter) are enabled with `define COMPUTEDRAM_STATUS_EN.
module computedram_sequencer #(
    parameter logic [2:0]  BANK = 3'd0,
    parameter int unsigned TRP  = 3,
    parameter int unsigned TRAS = 6
) (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic        init_done,
    input  logic [9:0]  ComputeDRAM_R1,
    input  logic [9:0]  ComputeDRAM_R2,
    input  logic [3:0]  ComputeDRAM_T1,
    input  logic [3:0]  ComputeDRAM_T2,
    input  logic        ComputeDRAM_vld,
    output logic        ComputeDRAM_rdy,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [14:0] dram_a,
    output logic [2:0]  dram_ba,
    output logic        dram_cs_n,
    output logic        dram_ras_n,
    output logic        dram_cas_n,
    output logic        dram_we_n
`ifdef COMPUTEDRAM_STATUS_EN
    ,
    output logic        ComputeDRAM_done,
    output logic [15:0] ComputeDRAM_count
`endif
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_REQ      = 4'd1;
    localparam logic [3:0] S_PREA     = 4'd2;
    localparam logic [3:0] S_WAIT_RP1 = 4'd3;
    localparam logic [3:0] S_ACT1     = 4'd4;
    localparam logic [3:0] S_WAIT_T1  = 4'd5;
    localparam logic [3:0] S_PRE      = 4'd6;
    localparam logic [3:0] S_WAIT_T2  = 4'd7;
    localparam logic [3:0] S_ACT2     = 4'd8;
    localparam logic [3:0] S_WAIT_RAS = 4'd9;
    localparam logic [3:0] S_PREA2    = 4'd10;
    localparam logic [3:0] S_WAIT_RP2 = 4'd11;

    // Command pin order is {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_ACT   = 4'b0011;

    localparam logic [7:0] TRP_C  = 8'(TRP);
    localparam logic [7:0] TRAS_C = 8'(TRAS);

    logic [3:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  r1_q, r1_d, r2_q, r2_d;
    logic [3:0]  t1_q, t1_d, t2_q, t2_d;
    logic        rdy_q, rdy_d;
    logic        bus_req_q, bus_req_d;
    logic [14:0] a_q, a_d;
    logic [2:0]  ba_q, ba_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        accept;

    assign accept = ComputeDRAM_vld && rdy_q;

    // Sequencing: a wait of length L loads L-1 into the counter; L=0 skips the wait state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_REQ;
                    r1_d    = ComputeDRAM_R1;
                    r2_d    = ComputeDRAM_R2;
                    t1_d    = ComputeDRAM_T1;
                    t2_d    = ComputeDRAM_T2;
                end
            end
            S_REQ: begin
                if (bus_gnt) state_d = S_PREA;
            end
            S_PREA: begin
                if (TRP_C == 8'd0) state_d = S_ACT1;
                else begin
                    state_d = S_WAIT_RP1;
                    cnt_d   = TRP_C - 8'd1;
                end
            end
            S_WAIT_RP1: begin
                if (cnt_q == 8'd0) state_d = S_ACT1;
                else cnt_d = cnt_q - 8'd1;
            end
            S_ACT1: begin
                if (t1_q == 4'd0) state_d = S_PRE;
                else begin
                    state_d = S_WAIT_T1;
                    cnt_d   = {4'd0, t1_q} - 8'd1;
                end
            end
            S_WAIT_T1: begin
                if (cnt_q == 8'd0) state_d = S_PRE;
                else cnt_d = cnt_q - 8'd1;
            end
            S_PRE: begin
                if (t2_q == 4'd0) state_d = S_ACT2;
                else begin
                    state_d = S_WAIT_T2;
                    cnt_d   = {4'd0, t2_q} - 8'd1;
                end
            end
            S_WAIT_T2: begin
                if (cnt_q == 8'd0) state_d = S_ACT2;
                else cnt_d = cnt_q - 8'd1;
            end
            S_ACT2: begin
                if (TRAS_C == 8'd0) state_d = S_PREA2;
                else begin
                    state_d = S_WAIT_RAS;
                    cnt_d   = TRAS_C - 8'd1;
                end
            end
            S_WAIT_RAS: begin
                if (cnt_q == 8'd0) state_d = S_PREA2;
                else cnt_d = cnt_q - 8'd1;
            end
            S_PREA2: begin
                if (TRP_C == 8'd0) state_d = S_IDLE;
                else begin
                    state_d = S_WAIT_RP2;
                    cnt_d   = TRP_C - 8'd1;
                end
            end
            S_WAIT_RP2: begin
                if (cnt_q == 8'd0) state_d = S_IDLE;
                else cnt_d = cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pins are decoded from the current state and registered, so they trail the state by one cycle.
    always_comb begin
        bus_req_d = (state_q != S_IDLE);
        cmd_d     = CMD_DESEL;
        a_d       = 15'd0;
        ba_d      = 3'd0;
        case (state_q)
            S_PREA, S_PREA2: begin
                cmd_d = CMD_PRE;
                a_d   = 15'h0400;
                ba_d  = BANK;
            end
            S_ACT1: begin
                cmd_d = CMD_ACT;
                a_d   = {5'd0, r1_q};
                ba_d  = BANK;
            end
            S_ACT2: begin
                cmd_d = CMD_ACT;
                a_d   = {5'd0, r2_q};
                ba_d  = BANK;
            end
            S_PRE: begin
                cmd_d = CMD_PRE;
                ba_d  = BANK;
            end
            S_WAIT_RP1, S_WAIT_T1, S_WAIT_T2, S_WAIT_RAS, S_WAIT_RP2: begin
                cmd_d = CMD_NOP;
                ba_d  = BANK;
            end
            default: ;
        endcase
        // Ready only once the bus has actually been handed back.
        rdy_d = (state_q == S_IDLE) && !bus_req_q && init_done && !accept;
    end

`ifdef COMPUTEDRAM_STATUS_EN
    logic        done_q, done_d;
    logic [15:0] count_q, count_d;

    always_comb begin
        done_d  = bus_req_q && !bus_req_d;
        count_d = count_q + {15'd0, done_d};
    end

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            done_q  <= 1'b0;
            count_q <= 16'd0;
        end else begin
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign ComputeDRAM_done  = done_q;
    assign ComputeDRAM_count = count_q;
`endif

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            r1_q      <= 10'd0;
            r2_q      <= 10'd0;
            t1_q      <= 4'd0;
            t2_q      <= 4'd0;
            rdy_q     <= 1'b0;
            bus_req_q <= 1'b0;
            a_q       <= 15'd0;
            ba_q      <= 3'd0;
            cmd_q     <= CMD_DESEL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r1_q      <= r1_d;
            r2_q      <= r2_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            rdy_q     <= rdy_d;
            bus_req_q <= bus_req_d;
            a_q       <= a_d;
            ba_q      <= ba_d;
            cmd_q     <= cmd_d;
        end
    end

    assign ComputeDRAM_rdy = rdy_q;
    assign bus_req         = bus_req_q;
    assign dram_a          = a_q;
    assign dram_ba         = ba_q;
    assign dram_cs_n       = cmd_q[3];
    assign dram_ras_n      = cmd_q[2];
    assign dram_cas_n      = cmd_q[1];
    assign dram_we_n       = cmd_q[0];

endmodule

// File: tb/tb_computedram_sequencer.sv
// Directed bench for computedram_sequencer: per-cycle command trace against an expected queue.
// Status outputs are exercised when COMPUTEDRAM_STATUS_EN is defined.
module tb_computedram_sequencer;

    localparam logic [2:0] BANK = 3'd5;
    localparam int TRP  = 3;
    localparam int TRAS = 6;

    localparam logic [3:0] P_DES = 4'b1111;
    localparam logic [3:0] P_NOP = 4'b0111;
    localparam logic [3:0] P_PRE = 4'b0010;
    localparam logic [3:0] P_ACT = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic [9:0]  r1 = 10'd0, r2 = 10'd0;
    logic [3:0]  t1 = 4'd0, t2 = 4'd0;
    logic        vld = 1'b0;
    logic        gnt = 1'b0;
    logic        rdy, bus_req;
    logic [14:0] dram_a;
    logic [2:0]  dram_ba;
    logic        cs_n, ras_n, cas_n, we_n;
`ifdef COMPUTEDRAM_STATUS_EN
    logic        done;
    logic [15:0] count;
    int          done_seen = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Word layout: {nop, rdy, bus_req, cs/ras/cas/we, ba, a}; nop masks ba and a.
    logic [24:0] exp_q[$];

    computedram_sequencer #(.BANK(BANK), .TRP(TRP), .TRAS(TRAS)) dut (
        .user_clk(clk),
        .user_rst_n(rst_n),
        .init_done(init_done),
        .ComputeDRAM_R1(r1),
        .ComputeDRAM_R2(r2),
        .ComputeDRAM_T1(t1),
        .ComputeDRAM_T2(t2),
        .ComputeDRAM_vld(vld),
        .ComputeDRAM_rdy(rdy),
        .bus_req(bus_req),
        .bus_gnt(gnt),
        .dram_a(dram_a),
        .dram_ba(dram_ba),
        .dram_cs_n(cs_n),
        .dram_ras_n(ras_n),
        .dram_cas_n(cas_n),
        .dram_we_n(we_n)
`ifdef COMPUTEDRAM_STATUS_EN
        ,
        .ComputeDRAM_done(done),
        .ComputeDRAM_count(count)
`endif
    );

    always #5 clk = ~clk;

`ifdef COMPUTEDRAM_STATUS_EN
    always @(negedge clk) if (done) done_seen++;
`endif

    function automatic logic [24:0] mk(input logic nop, input logic rdy_e, input logic breq,
                                       input logic [3:0] pins, input logic [2:0] ba,
                                       input logic [14:0] a);
        return {nop, rdy_e, breq, pins, ba, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [24:0] exp);
        logic [24:0] obs;
        logic [24:0] e;
        obs = {1'b0, rdy, bus_req, cs_n, ras_n, cas_n, we_n, dram_ba, dram_a};
        e   = exp;
        if (e[24]) begin
            e[24]   = 1'b0;
            e[17:0] = 18'd0;
            obs[17:0] = 18'd0;
        end
        chk(tag, {7'd0, obs}, {7'd0, e});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one request from an idle, ready DUT and checks every cycle from the accept onward.
    // delay: cycles bus_gnt stays low after accept; busy: pulse vld while busy; abort_at: cycle to reset at (-1 none).
    task automatic run_op(input logic [9:0] ra, input logic [9:0] rb, input logic [3:0] ta,
                          input logic [3:0] tb_, input int delay, input bit busy, input int abort_at);
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 0, P_DES, 0, 0));
        repeat (delay + 1) exp_q.push_back(mk(0, 0, 1, P_DES, 0, 0));
        exp_q.push_back(mk(0, 0, 1, P_PRE, BANK, 15'h400));
        repeat (TRP) exp_q.push_back(mk(1, 0, 1, P_NOP, 0, 0));
        exp_q.push_back(mk(0, 0, 1, P_ACT, BANK, {5'd0, ra}));
        repeat (int'(ta)) exp_q.push_back(mk(1, 0, 1, P_NOP, 0, 0));
        exp_q.push_back(mk(0, 0, 1, P_PRE, BANK, 15'h000));
        repeat (int'(tb_)) exp_q.push_back(mk(1, 0, 1, P_NOP, 0, 0));
        exp_q.push_back(mk(0, 0, 1, P_ACT, BANK, {5'd0, rb}));
        repeat (TRAS) exp_q.push_back(mk(1, 0, 1, P_NOP, 0, 0));
        exp_q.push_back(mk(0, 0, 1, P_PRE, BANK, 15'h400));
        repeat (TRP) exp_q.push_back(mk(1, 0, 1, P_NOP, 0, 0));
        exp_q.push_back(mk(0, 0, 0, P_DES, 0, 0));
        exp_q.push_back(mk(0, 1, 0, P_DES, 0, 0));
        exp_q.push_back(mk(0, 1, 0, P_DES, 0, 0));

        r1  = ra;
        r2  = rb;
        t1  = ta;
        t2  = tb_;
        vld = 1'b1;
        gnt = (delay == 0);
        step();
        vld = 1'b0;
        // Fields are only sampled at accept, so scramble them afterwards.
        r1 = 10'($urandom_range(0, 1023));
        r2 = 10'($urandom_range(0, 1023));
        t1 = 4'($urandom_range(0, 15));
        t2 = 4'($urandom_range(0, 15));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk_word($sformatf("op_r1_%0h_cyc%0d", ra, i), exp_q[i]);
            if (i == abort_at) begin
                rst_n = 1'b0;
                step();
                chk_word("abort_idle", mk(0, 0, 0, P_DES, 0, 0));
                rst_n = 1'b1;
                step();
                chk_word("abort_rdy", mk(0, 1, 0, P_DES, 0, 0));
                return;
            end
            if (i == delay) gnt = 1'b1;
            vld = (busy && i >= 2 && i <= 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        vld = 1'b0;
    endtask

    initial begin
        // Reset with init low: deselected, not ready, vld ignored.
        rst_n     = 1'b0;
        init_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_word("reset", mk(0, 0, 0, P_DES, 0, 0));
        rst_n = 1'b1;
        vld   = 1'b1;
        step();
        step();
        chk_word("no_init", mk(0, 0, 0, P_DES, 0, 0));
        vld       = 1'b0;
        init_done = 1'b1;
        chk("rdy_before_init_seen", {31'd0, rdy}, 32'd0);
        step();
        chk_word("init_rdy", mk(0, 1, 0, P_DES, 0, 0));

        // Nominal timing example.
        run_op(10'd4, 10'd5, 4'd2, 4'd2, 0, 1'b0, -1);
        // Zero gaps, edge rows.
        run_op(10'h3FF, 10'h000, 4'd0, 4'd0, 0, 1'b0, -1);
        // Grant held low for 5 cycles after accept.
        run_op(10'd7, 10'd9, 4'd1, 4'd3, 5, 1'b0, -1);
        // vld pulsed while busy: exactly one op, then idle-ready.
        run_op(10'd4, 10'd5, 4'd2, 4'd2, 0, 1'b1, -1);
        // Reset during ACT2 output cycle.
        run_op(10'd4, 10'd5, 4'd2, 4'd2, 0, 1'b0, 12);

`ifdef COMPUTEDRAM_STATUS_EN
        begin
            int d0;
            d0 = done_seen;
            chk("count_after_abort", {16'd0, count}, 32'd0);
            run_op(10'd1, 10'd2, 4'd1, 4'd1, 0, 1'b0, -1);
            run_op(10'd3, 10'd4, 4'd0, 4'd2, 0, 1'b0, -1);
            run_op(10'd5, 10'd6, 4'd2, 4'd0, 0, 1'b0, -1);
            chk("done_pulses", done_seen - d0, 32'd3);
            chk("count_three", {16'd0, count}, 32'd3);
            dut.count_q = 16'hFFFF;
            run_op(10'd8, 10'd9, 4'd1, 4'd1, 0, 1'b0, -1);
            chk("count_wrap", {16'd0, count}, 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
